// File: rtl/dcache_refill_ctrl.sv
// Miss-side refill controller for a 2-way data cache: burst line fetch, one-cycle array write,
// per-set 1-bit LRU victim selection. Optional error tracking under DCACHE_REFILL_ERR_EN.
module dcache_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH  = 4,
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned BEAT_WIDTH   = 32,
    parameter int unsigned WAY          = 2,
    localparam int unsigned BEATS       = (2 ** OFFSET_WIDTH) * 8 / BEAT_WIDTH,
    localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
    localparam int unsigned LINE_W      = BEATS * BEAT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_valid,
    input  logic [ADDR_WIDTH-1:0]  miss_addr,
    output logic                   miss_ready,
    output logic                   mem_rd_req,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic                   mem_rd_ack,
    input  logic                   mem_rd_valid,
    input  logic [BEAT_WIDTH-1:0]  mem_rd_data,
    input  logic                   mem_rd_last,
`ifdef DCACHE_REFILL_ERR_EN
    input  logic                   mem_rd_err,
    output logic                   refill_err,
`endif
    input  logic                   access_valid,
    input  logic [INDEX_WIDTH-1:0] access_index,
    input  logic                   access_way,
    output logic [WAY-1:0]         tagv_we,
    output logic [INDEX_WIDTH-1:0] tagv_addr,
    output logic [TAG_WIDTH:0]     tagv_din,
    output logic [WAY-1:0]         data_we,
    output logic [INDEX_WIDTH-1:0] data_addr,
    output logic [LINE_W-1:0]      data_din,
    output logic                   refill_done,
    output logic                   refill_way
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SETS  = 2 ** INDEX_WIDTH;

    typedef enum logic [2:0] {StIdle, StReq, StRecv, StWrite, StDone} state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [INDEX_WIDTH-1:0]  r_index;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic                    r_victim;
    logic [CNT_W-1:0]        r_cnt;
    logic [LINE_W-1:0]       r_line;
    logic [SETS-1:0]         r_lru;
    logic                    r_refill_way;
    logic                    w_accept;
    logic                    w_beat;
    logic                    w_bad;
    logic                    w_unused_offset;

    assign w_accept        = (r_state == StIdle) && miss_valid;
    assign w_beat          = (r_state == StRecv) && mem_rd_valid;
    assign w_unused_offset = ^miss_addr[OFFSET_WIDTH-1:0];

`ifdef DCACHE_REFILL_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_beat && mem_rd_err) begin
            r_err <= 1'b1;
        end
    end

    assign w_bad      = r_err;
    assign refill_err = (r_state == StDone) && r_err;
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        miss_ready   = 1'b0;
        mem_rd_req   = 1'b0;
        tagv_we      = '0;
        data_we      = '0;
        tagv_din     = '0;
        refill_done  = 1'b0;
        unique case (r_state)
            StIdle: begin
                miss_ready = 1'b1;
                if (miss_valid) w_state_next = StReq;
            end
            StReq: begin
                mem_rd_req = 1'b1;
                if (mem_rd_ack) w_state_next = StRecv;
            end
            StRecv: begin
                if (mem_rd_valid && (mem_rd_last || r_cnt == CNT_W'(BEATS - 1))) begin
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                tagv_we[r_victim] = 1'b1;
                data_we[r_victim] = 1'b1;
                tagv_din          = {~w_bad, r_tag};
                w_state_next      = StDone;
            end
            StDone: begin
                refill_done  = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_index      <= '0;
            r_tag        <= '0;
            r_victim     <= 1'b0;
            r_cnt        <= '0;
            r_line       <= '0;
            r_lru        <= '0;
            r_refill_way <= 1'b0;
        end else begin
            if (access_valid) r_lru[access_index] <= ~access_way;
            if (w_accept) begin
                r_addr   <= {miss_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                r_index  <= miss_addr[OFFSET_WIDTH +: INDEX_WIDTH];
                r_tag    <= miss_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                r_victim <= r_lru[miss_addr[OFFSET_WIDTH +: INDEX_WIDTH]];
                r_cnt    <= '0;
                r_line   <= '0;
            end
            if (w_beat) begin
                r_line[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rd_data;
                r_cnt <= (r_cnt == CNT_W'(BEATS - 1)) ? '0 : r_cnt + 1'b1;
            end
            // Placed after the hit update so a refill to the same set takes priority.
            if (r_state == StWrite) begin
                if (!w_bad) r_lru[r_index] <= ~r_victim;
                r_refill_way <= r_victim;
            end
        end
    end

    assign mem_rd_addr = r_addr;
    assign tagv_addr   = r_index;
    assign data_addr   = r_index;
    assign data_din    = r_line;
    assign refill_way  = r_refill_way;

endmodule
